// File: rtl/hex_display_driver_pkg.sv
// Shared types and constants for the two-digit hex display driver:
// scan FSM encodings and the hex-to-seven-segment table.
package hex_display_driver_pkg;

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam int unsigned CNT_W = 24;

endpackage

// File: rtl/hex_display_driver_if.sv
// Value/decimal-point inputs and display pins of the hex display driver.
interface hex_display_driver_if;

    logic [7:0] value;
    logic [1:0] dp_mask;
    logic       blank_leading_zero;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_en;

    modport master (
        output value,
        output dp_mask,
        output blank_leading_zero,
        input  seg,
        input  dp,
        input  digit_en
    );

    modport slave (
        input  value,
        input  dp_mask,
        input  blank_leading_zero,
        output seg,
        output dp,
        output digit_en
    );

endinterface

// File: rtl/hex_display_driver_hex_to_seg.sv
// Combinational nibble to seven-segment encoder (active-high segments).
module hex_to_seg (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    import hex_display_driver_pkg::*;

    assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/hex_display_driver.sv
// Two-digit multiplexed seven-segment driver with blanking gaps and a
// frame-boundary shadow register so a digit pair never tears mid-frame.
module hex_display_driver #(
    parameter int unsigned cycles_per_digit   = 12000,
    parameter int unsigned blank_cycles       = 12,
    parameter bit          active_low_outputs = 1'b1
) (
    input logic                 clock,
    input logic                 reset_n,
    hex_display_driver_if.slave bus
);
    import hex_display_driver_pkg::*;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(cycles_per_digit - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(blank_cycles - 1);
    localparam logic [6:0]       POL7       = {7{active_low_outputs}};
    localparam logic [1:0]       POL2       = {2{active_low_outputs}};

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_val;
    logic [1:0]         r_dpm;
    logic               r_blz;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic [1:0]         r_en;

    logic               w_show;
    logic               w_last;
    logic               w_load;
    logic               w_hide1;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg;

    assign w_show  = (r_state == SHOW0) || (r_state == SHOW1);
    assign w_last  = (r_cnt == (w_show ? SHOW_LAST : BLANK_LAST));
    assign w_load  = (r_state == BLANK0) && (r_cnt == '0);
    assign w_hide1 = r_blz && (r_val[7:4] == 4'h0);
    assign w_nib   = (r_state == SHOW1) ? r_val[7:4] : r_val[3:0];

    hex_to_seg u_enc (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BLANK0;
            r_cnt   <= '0;
            r_val   <= '0;
            r_dpm   <= '0;
            r_blz   <= 1'b0;
            r_seg   <= '0;
            r_dp    <= 1'b0;
            r_en    <= '0;
        end else begin
            if (w_load) begin
                r_val <= bus.value;
                r_dpm <= bus.dp_mask;
                r_blz <= bus.blank_leading_zero;
            end

            if (w_last) begin
                r_cnt   <= '0;
                r_state <= state_t'(r_state + 2'd1);
            end else begin
                r_cnt   <= r_cnt + 1'b1;
            end

            // Pins follow the state one clock later; blank is the default.
            r_en  <= 2'b00;
            r_seg <= '0;
            r_dp  <= 1'b0;
            unique case (r_state)
                SHOW0: begin
                    r_en  <= 2'b01;
                    r_seg <= w_seg;
                    r_dp  <= r_dpm[0];
                end
                SHOW1: begin
                    if (!w_hide1) begin
                        r_en  <= 2'b10;
                        r_seg <= w_seg;
                        r_dp  <= r_dpm[1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.seg      = r_seg ^ POL7;
    assign bus.dp       = r_dp ^ active_low_outputs;
    assign bus.digit_en = r_en ^ POL2;

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed self-checking bench for hex_display_driver across three parameter sets.
module tb_hex_display_driver;

    logic clock;
    logic reset_n;
    int   total;
    int   bad;
    int   cyc;

    logic [6:0] ENC [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    hex_display_driver_if ifa ();
    hex_display_driver_if ifb ();
    hex_display_driver_if ifc ();

    hex_display_driver #(
        .cycles_per_digit   (4),
        .blank_cycles       (1),
        .active_low_outputs (1'b0)
    ) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifa)
    );

    hex_display_driver #(
        .cycles_per_digit   (4),
        .blank_cycles       (1),
        .active_low_outputs (1'b1)
    ) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifb)
    );

    hex_display_driver #(
        .cycles_per_digit   (1),
        .blank_cycles       (1),
        .active_low_outputs (1'b0)
    ) dut_c (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {digit_en, dp, seg} (active-high), 10-clock frame.
    function automatic logic [9:0] pat10(int k, logic [7:0] v,
                                         logic [1:0] dpm, logic blz);
        int p;
        p = (k - 1) % 10;
        if (p >= 1 && p <= 4)
            return {2'b01, dpm[0], ENC[v[3:0]]};
        if (p >= 6) begin
            if (blz && v[7:4] == 4'h0)
                return 10'h000;
            return {2'b10, dpm[1], ENC[v[7:4]]};
        end
        return 10'h000;
    endfunction

    // Expected pattern for the 4-clock frame of dut_c.
    function automatic logic [9:0] pat4(int k, logic [7:0] v);
        int p;
        p = (k - 1) % 4;
        if (p == 1)
            return {2'b01, 1'b0, ENC[v[3:0]]};
        if (p == 3)
            return {2'b10, 1'b0, ENC[v[7:4]]};
        return 10'h000;
    endfunction

    function automatic logic [9:0] obs(logic [1:0] en, logic d, logic [6:0] s);
        return {en, d, s};
    endfunction

    task automatic set_in(logic [7:0] v, logic [1:0] dpm, logic blz);
        ifa.value = v; ifa.dp_mask = dpm; ifa.blank_leading_zero = blz;
        ifb.value = v; ifb.dp_mask = dpm; ifb.blank_leading_zero = blz;
        ifc.value = v; ifc.dp_mask = dpm; ifc.blank_leading_zero = blz;
    endtask

    task automatic do_reset(logic [7:0] v, logic [1:0] dpm, logic blz);
        @(negedge clock);
        reset_n = 1'b0;
        set_in(v, dpm, blz);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic step;
        @(negedge clock);
        cyc++;
    endtask

    task automatic test_reset;
        logic [9:0] oa, ob;
        do_reset(8'h3C, 2'b00, 1'b0);
        repeat (8) step();
        reset_n = 1'b0;
        #1;
        ob = obs(ifb.digit_en, ifb.dp, ifb.seg);
        total++;
        if (ob !== 10'h3FF) begin
            bad++;
            $display("FAIL reset_async_b got=%h want=%h", ob, 10'h3FF);
        end
        oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
        total++;
        if (oa !== 10'h000) begin
            bad++;
            $display("FAIL reset_async_a got=%h want=%h", oa, 10'h000);
        end
        @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
        step();
        set_in(8'hFF, 2'b11, 1'b0);
        ob = obs(ifb.digit_en, ifb.dp, ifb.seg);
        total++;
        if (ob !== 10'h3FF) begin
            bad++;
            $display("FAIL reset_first_blank got=%h want=%h", ob, 10'h3FF);
        end
        step();
        ob = obs(ifb.digit_en, ifb.dp, ifb.seg);
        total++;
        if (ob !== {2'b10, 1'b1, 7'h46}) begin
            bad++;
            $display("FAIL reset_first_digit0 got=%h want=%h", ob,
                     {2'b10, 1'b1, 7'h46});
        end
        repeat (5) step();
        oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
        total++;
        if (oa !== {2'b10, 1'b0, 7'h4F}) begin
            bad++;
            $display("FAIL reset_first_digit1 got=%h want=%h", oa,
                     {2'b10, 1'b0, 7'h4F});
        end
    endtask

    task automatic test_scan;
        logic [9:0] oa, ob, oc, ea, ec;
        do_reset(8'hA5, 2'b00, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            step();
            ea = pat10(k, 8'hA5, 2'b00, 1'b0);
            ec = pat4(k, 8'hA5);
            oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
            ob = obs(ifb.digit_en, ifb.dp, ifb.seg);
            oc = obs(ifc.digit_en, ifc.dp, ifc.seg);
            total++;
            if (oa !== ea) begin
                bad++;
                $display("FAIL scan_a k=%0d got=%h want=%h", k, oa, ea);
            end
            total++;
            if (ob !== ~ea) begin
                bad++;
                $display("FAIL scan_b k=%0d got=%h want=%h", k, ob, ~ea);
            end
            total++;
            if (oc !== ec) begin
                bad++;
                $display("FAIL scan_c k=%0d got=%h want=%h", k, oc, ec);
            end
            total++;
            if (ifc.digit_en === 2'b11) begin
                bad++;
                $display("FAIL onehot_c k=%0d got=%b want=not 11", k,
                         ifc.digit_en);
            end
        end
    endtask

    task automatic test_tear;
        logic [9:0] oa, ea;
        do_reset(8'h12, 2'b00, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 3)
                set_in(8'h34, 2'b00, 1'b0);
            ea = pat10(k, (k <= 10) ? 8'h12 : 8'h34, 2'b00, 1'b0);
            oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
            total++;
            if (oa !== ea) begin
                bad++;
                $display("FAIL tear k=%0d got=%h want=%h", k, oa, ea);
            end
        end
    endtask

    task automatic test_leading_zero;
        logic [9:0] oa;
        do_reset(8'h07, 2'b00, 1'b1);
        repeat (2) step();
        oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
        total++;
        if (oa !== {2'b01, 1'b0, 7'h07}) begin
            bad++;
            $display("FAIL blz07_d0 got=%h want=%h", oa, {2'b01, 1'b0, 7'h07});
        end
        repeat (5) step();
        oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
        total++;
        if (oa !== 10'h000) begin
            bad++;
            $display("FAIL blz07_d1 got=%h want=%h", oa, 10'h000);
        end
        do_reset(8'h70, 2'b00, 1'b1);
        repeat (2) step();
        oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
        total++;
        if (oa !== {2'b01, 1'b0, 7'h3F}) begin
            bad++;
            $display("FAIL blz70_d0 got=%h want=%h", oa, {2'b01, 1'b0, 7'h3F});
        end
        repeat (5) step();
        oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
        total++;
        if (oa !== {2'b10, 1'b0, 7'h07}) begin
            bad++;
            $display("FAIL blz70_d1 got=%h want=%h", oa, {2'b10, 1'b0, 7'h07});
        end
    endtask

    task automatic test_encoder_sweep;
        logic [9:0] oa, ob, ea;
        logic [7:0] cur;
        int f;
        do_reset(8'h00, 2'b00, 1'b0);
        for (int k = 1; k <= 160; k++) begin
            step();
            f = (k - 1) / 10;
            cur = 8'(f * 17);
            if ((k - 1) % 10 == 2 && f < 15)
                set_in(8'((f + 1) * 17), 2'b00, 1'b0);
            ea = pat10(k, cur, 2'b00, 1'b0);
            oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
            ob = obs(ifb.digit_en, ifb.dp, ifb.seg);
            total++;
            if (oa !== ea) begin
                bad++;
                $display("FAIL sweep_a k=%0d got=%h want=%h", k, oa, ea);
            end
            total++;
            if (ob !== ~ea) begin
                bad++;
                $display("FAIL sweep_b k=%0d got=%h want=%h", k, ob, ~ea);
            end
        end
    endtask

    task automatic test_dp;
        logic [9:0] oa, ob, ea;
        do_reset(8'h00, 2'b10, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            ea = pat10(k, 8'h00, 2'b10, 1'b0);
            oa = obs(ifa.digit_en, ifa.dp, ifa.seg);
            ob = obs(ifb.digit_en, ifb.dp, ifb.seg);
            total++;
            if (oa !== ea) begin
                bad++;
                $display("FAIL dp_a k=%0d got=%h want=%h", k, oa, ea);
            end
            total++;
            if (ob !== ~ea) begin
                bad++;
                $display("FAIL dp_b k=%0d got=%h want=%h", k, ob, ~ea);
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        reset_n = 1'b0;
        set_in(8'h00, 2'b00, 1'b0);
        test_reset();
        test_scan();
        test_tear();
        test_leading_zero();
        test_encoder_sweep();
        test_dp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
